// File: rtl/fb_pkg.sv
// Shared constants, state encoding and helpers for the frame-buffer write path.
package fb_pkg;

    localparam int unsigned IMG_W     = 260;
    localparam int unsigned IMG_H     = 120;
    localparam int unsigned ADDR_W    = 16;
    localparam int unsigned PIX_W     = 12;
    localparam int unsigned COL_W     = 10;
    localparam int unsigned ROW_W     = $clog2(IMG_H + 1);
    localparam int unsigned FRAME_PIX = IMG_W * IMG_H;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } fb_wr_state_t;

    // Out-of-range column bases fall back to column 0.
    function automatic logic [COL_W-1:0] clamp_col(input logic [COL_W-1:0] c);
        return (32'(c) >= IMG_W) ? '0 : c;
    endfunction

endpackage

// File: rtl/fb_wr_counter.sv
// Column/row address counters for the frame-buffer writer; addr = row_base + column.
module fb_wr_counter
    import fb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              adv,
    input  logic              mirror,
    input  logic [COL_W-1:0]  col_base,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);

    logic [COL_W-1:0]  col;
    logic [COL_W-1:0]  row_cnt;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] row_base;
    logic              mirror_q;
    logic [COL_W-1:0]  base_eff;
    logic              row_end;

    assign base_eff = clamp_col(col_base);
    assign row_end  = (row_cnt == COL_MAX);

    // Rotated column wraps on its own; row_cnt alone decides end of row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col      <= '0;
            row_cnt  <= '0;
            row      <= '0;
            row_base <= '0;
            mirror_q <= 1'b0;
        end else if (load) begin
            mirror_q <= mirror;
            col      <= mirror ? (COL_MAX - base_eff) : base_eff;
            row_cnt  <= '0;
            row      <= '0;
            row_base <= '0;
        end else if (adv) begin
            if (mirror_q)
                col <= (col == '0) ? COL_MAX : col - COL_W'(1);
            else
                col <= (col == COL_MAX) ? '0 : col + COL_W'(1);
            if (row_end) begin
                row_cnt  <= '0;
                row      <= row + ROW_W'(1);
                row_base <= row_base + ADDR_W'(IMG_W);
            end else begin
                row_cnt  <= row_cnt + COL_W'(1);
            end
        end
    end

    assign addr = row_base + ADDR_W'(col);
    assign last = row_end && (row == ROW_MAX);

endmodule

// File: rtl/fb_write_gen.sv
// Frame-buffer write-side address generator: pixel stream in, RAM write port out.
// Optional build macro FB_WR_MIRROR_EN adds a horizontal mirror input.
module fb_write_gen
    import fb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [COL_W-1:0]  col_base,
`ifdef FB_WR_MIRROR_EN
    input  logic              mirror,
`endif
    input  logic              abort,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_data,
    output logic              pix_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              busy,
    output logic              done
);

    fb_wr_state_t      state;
    logic              load;
    logic              accept;
    logic              last;
    logic              mirror_in;
    logic [ADDR_W-1:0] addr;

`ifdef FB_WR_MIRROR_EN
    assign mirror_in = mirror;
`else
    assign mirror_in = 1'b0;
`endif

    // Abort withdraws ready in the same cycle so a racing pixel is never taken.
    assign pix_ready = (state == LOAD) && !abort;
    assign accept    = pix_valid && pix_ready;
    assign load      = (state == IDLE) && start;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    fb_wr_counter u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .adv      (accept),
        .mirror   (mirror_in),
        .col_base (col_base),
        .addr     (addr),
        .last     (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= accept;
            if (accept) begin
                wr_addr <= addr;
                wr_data <= pix_data;
            end
            case (state)
                IDLE:    if (start) state <= LOAD;
                LOAD: begin
                    if (abort)               state <= IDLE;
                    else if (accept && last) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_write_gen.sv
// Self-checking bench for fb_write_gen: directed frames, rotation, backpressure, abort, reset.
`timescale 1ns/1ps
module tb_fb_write_gen;
    import fb_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [COL_W-1:0]  col_base;
`ifdef FB_WR_MIRROR_EN
    logic              mirror;
`endif
    logic              abort;
    logic              pix_valid;
    logic [PIX_W-1:0]  pix_data;
    logic              pix_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]  wr_data;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    fb_write_gen dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .col_base  (col_base),
`ifdef FB_WR_MIRROR_EN
        .mirror    (mirror),
`endif
        .abort     (abort),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .pix_ready (pix_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int wa[$];
    int wd[$];
    int exp_d[$];
    int dval;
    int done_cnt;
    int neg_cyc = 0;
    int start_cyc = 0;
    int done_cyc = 0;

    // Write/done monitor, sampled mid-cycle.
    always @(negedge clk) begin
        neg_cyc++;
        if (!rst) begin
            if (start && !busy) start_cyc = neg_cyc;
            if (wr_en) begin
                wa.push_back(int'(wr_addr));
                wd.push_back(int'(wr_data));
            end
            if (done) begin
                done_cnt++;
                done_cyc = neg_cyc;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        exp_d.delete();
        done_cnt = 0;
        dval = 0;
    endtask

    task automatic do_start(input int cb, input bit mir);
        col_base = COL_W'(cb);
`ifdef FB_WR_MIRROR_EN
        mirror = mir;
`else
        if (mir) $display("mirror request ignored in this build");
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Drive pixels until n are accepted; inj pulses start at that accept count.
    task automatic run_pixels(input int n, input bit rnd, input int inj);
        int nacc = 0;
        int guard = 0;
        while (nacc < n && guard < 20 * n + 100) begin
            pix_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            pix_data  = PIX_W'(dval);
            start     = (nacc == inj);
            #1;
            if (pix_valid && pix_ready) begin
                exp_d.push_back(dval % (1 << PIX_W));
                dval++;
                nacc++;
            end
            tick();
            guard++;
        end
        start     = 1'b0;
        pix_valid = 1'b0;
        if (nacc < n) chk("accept_timeout", nacc, n);
    endtask

    task automatic do_abort();
        abort     = 1'b1;
        pix_valid = 1'b1;
        tick();
        abort     = 1'b0;
        pix_valid = 1'b0;
    endtask

    function automatic int seq_errors(input bit addr_mode);
        int bad = 0;
        if (addr_mode) begin
            foreach (wa[i]) if (wa[i] != i) bad++;
        end else begin
            if (wd.size() != exp_d.size()) bad++;
            foreach (wd[i]) if (i < exp_d.size() && wd[i] != exp_d[i]) bad++;
        end
        return bad;
    endfunction

    typedef struct {
        int    scen;
        int    idx;
        int    exp_addr;
        string name;
    } vec_t;

    vec_t vecs[$];

    task automatic check_table(input int scen);
        foreach (vecs[i]) begin
            if (vecs[i].scen == scen) begin
                if (vecs[i].idx < wa.size())
                    chk(vecs[i].name, wa[vecs[i].idx], vecs[i].exp_addr);
                else
                    chk({vecs[i].name, "_missing"}, wa.size(), vecs[i].idx + 1);
            end
        end
    endtask

    initial begin
        vecs.push_back('{0, 0,     0,     "frame_w1"});
        vecs.push_back('{0, 259,   259,   "frame_w260"});
        vecs.push_back('{0, 260,   260,   "frame_w261"});
        vecs.push_back('{0, 31199, 31199, "frame_wlast"});
        vecs.push_back('{1, 0,     100,   "rot_w1"});
        vecs.push_back('{1, 159,   259,   "rot_row0_end"});
        vecs.push_back('{1, 160,   0,     "rot_wrap"});
        vecs.push_back('{1, 259,   99,    "rot_row0_last"});
        vecs.push_back('{1, 260,   360,   "rot_row1_first"});
        vecs.push_back('{2, 0,     0,     "cb300_w1"});
        vecs.push_back('{2, 259,   259,   "cb300_w260"});
        vecs.push_back('{2, 260,   260,   "cb300_w261"});
`ifdef FB_WR_MIRROR_EN
        vecs.push_back('{3, 0,     259,   "mir_w1"});
        vecs.push_back('{3, 259,   0,     "mir_w260"});
        vecs.push_back('{3, 260,   519,   "mir_w261"});
`endif

        rst = 1'b1; start = 1'b0; abort = 1'b0; pix_valid = 1'b0;
        pix_data = '0; col_base = '0;
`ifdef FB_WR_MIRROR_EN
        mirror = 1'b0;
`endif
        clear_log();
        tick(); tick();
        chk("rst_pix_ready", int'(pix_ready), 0);
        chk("rst_wr_en",     int'(wr_en),     0);
        chk("rst_wr_addr",   int'(wr_addr),   0);
        chk("rst_busy",      int'(busy),      0);
        chk("rst_done",      int'(done),      0);
        rst = 1'b0;
        tick();

        // Full frame, col_base 0, with a stray start mid-load.
        clear_log();
        do_start(0, 1'b0);
        chk("start_busy",  int'(busy),      1);
        chk("start_ready", int'(pix_ready), 1);
        run_pixels(FRAME_PIX, 1'b0, 100);
        chk("final_done",  int'(done),      1);
        chk("final_wr_en", int'(wr_en),     1);
        chk("final_ready", int'(pix_ready), 0);
        tick();
        chk("after_done_busy", int'(busy), 0);
        tick(); tick();
        chk("frame_writes",  wa.size(), FRAME_PIX);
        chk("frame_done_n",  done_cnt, 1);
        chk("frame_latency", done_cyc - start_cyc, FRAME_PIX + 1);
        chk("frame_addr_seq", seq_errors(1'b1), 0);
        chk("frame_data_seq", seq_errors(1'b0), 0);
        check_table(0);

        // Rotation by 100, then an out-of-range base.
        clear_log();
        do_start(100, 1'b0);
        run_pixels(300, 1'b0, -1);
        do_abort();
        tick(); tick();
        check_table(1);

        clear_log();
        do_start(300, 1'b0);
        run_pixels(300, 1'b0, -1);
        do_abort();
        tick(); tick();
        check_table(2);

`ifdef FB_WR_MIRROR_EN
        clear_log();
        do_start(0, 1'b1);
        run_pixels(300, 1'b0, -1);
        do_abort();
        tick(); tick();
        check_table(3);
`endif

        // Backpressure with abort after 500 accepts.
        clear_log();
        do_start(0, 1'b0);
        run_pixels(500, 1'b1, -1);
        abort = 1'b1;
        pix_valid = 1'b1;
        #1;
        chk("abort_ready", int'(pix_ready), 0);
        chk("abort_last_write", int'(wr_en), 1);
        tick();
        abort = 1'b0;
        pix_valid = 1'b0;
        chk("abort_busy", int'(busy), 0);
        tick(); tick(); tick();
        chk("abort_writes", wa.size(), 500);
        chk("abort_data_seq", seq_errors(1'b0), 0);
        chk("abort_done_n", done_cnt, 0);

        // Reset mid-load, then restart.
        clear_log();
        do_start(50, 1'b0);
        run_pixels(1000, 1'b0, -1);
        rst = 1'b1;
        #1;
        chk("mid_rst_wr_en",   int'(wr_en),     0);
        chk("mid_rst_wr_addr", int'(wr_addr),   0);
        chk("mid_rst_wr_data", int'(wr_data),   0);
        chk("mid_rst_ready",   int'(pix_ready), 0);
        chk("mid_rst_busy",    int'(busy),      0);
        tick(); tick();
        rst = 1'b0;
        clear_log();
        pix_valid = 1'b1;
        tick(); tick(); tick();
        chk("post_rst_writes", wa.size(), 0);
        do_start(50, 1'b0);
        run_pixels(1, 1'b0, -1);
        tick();
        chk("restart_first_addr", (wa.size() > 0) ? wa[0] : -1, 50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
